booth_seq_ctrl: RTL
===================

// Module: booth_seq_ctrl
// PURPOSE
//  Sequencer for the iterative radix-4 Booth multiplier built around the N_register product register.
//  - Accepts a multiply request and issues the register's load, then one add-and-shift step per recoded digit.
//  - Recodes the register's low 3 bits into a partial-product select per step.
//  - Presents a held done/result-valid handshake to the consumer.
// PARAMETERS
//  WIDTH_REGISTER  32  operand width; must be even. Localparam ITERS = WIDTH_REGISTER/2; CW = $clog2(ITERS+1).
// PORTS
//  clk             in   1     single clock, rising edge
//  n_rst           in   1     asynchronous active-low reset
//  i_start_valid   in   1     multiply request; operands are stable on datapath while high
//  o_start_ready   out  1     high only in IDLE
//  i_abort         in   1     cancel the current operation
//  i_reg_lsb       in   3     {P[1],P[0],P[-1]} from the product register
//  o_reg_load      out  1     load multiplier/clear accumulator (N_register load)
//  o_reg_step      out  1     add selected partial product, then arithmetic shift right by 2
//  o_pp_en         out  1     partial product is non-zero
//  o_pp_neg        out  1     subtract (two's-complement) the multiplicand
//  o_pp_x2         out  1     use 2x multiplicand
//  o_iter          out  CW    completed step count
//  o_busy          out  1     high in LOAD/STEP
//  o_done_valid    out  1     product in register is final
//  i_done_ready    in   1     consumer accepts the result
// BEHAVIOUR
//  - Reset (async, n_rst=0): state=IDLE; all outputs 0 except o_start_ready=1; o_iter=0.
//  - FSM states: IDLE, LOAD, STEP, DONE.
//    - IDLE -> LOAD on i_start_valid (handshake cycle T0).
//    - LOAD: o_reg_load=1 for 1 cycle (T1); o_iter cleared -> STEP.
//    - STEP: o_reg_step=1 each cycle; o_iter++ each cycle; after ITERS steps -> DONE.
//    - DONE: o_done_valid=1, held until i_done_ready -> IDLE.
//  - Timing with W=32: steps occupy T2..T17; o_done_valid rises at T18.
//    - Latency start-accept -> done = ITERS+2 cycles.
//  - Recode (i_reg_lsb -> en/neg/x2), outputs driven only in STEP and 0 elsewhere:
//    - 000,111 -> 0/0/0; 001,010 -> 1/0/0; 011 -> 1/0/1; 100 -> 1/1/1; 101,110 -> 1/1/0.
//  - Handshakes:
//    - o_start_ready is combinational from state (IDLE only); start while busy/done is ignored.
//    - Done handshake and new start never share a cycle; next accept is earliest the cycle after DONE exits.
//  - Abort: i_abort in LOAD/STEP/DONE -> IDLE next cycle, no done pulse, o_iter=0; ignored in IDLE.
//    - Abort in the same cycle as i_done_ready also returns to IDLE; the result counts as not delivered.
//  - o_iter saturates at ITERS; no wrap.
//  - Reset mid-operation: immediate IDLE, register strobes deasserted asynchronously.
// CONFIGURATION
//  BOOTH_STAT_EN defined:
//    - Adds out port o_op_count[15:0]: completed (done-handshaked) multiplies.
//    - Adds out port o_nz_digits[15:0]: cumulative STEP cycles with o_pp_en=1.
//    - Both counters saturate at 16'hFFFF and clear on reset only.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  booth_pkg:
//    - typedef enum logic [1:0] booth_state_t {IDLE,LOAD,STEP,DONE}.
//    - typedef struct packed {en,neg,x2} booth_pp_t.
//    - function booth_recode(logic [2:0]) returning booth_pp_t.
//  Sub-module booth_recoder: combinational wrapper of booth_recode, gated by STEP.
//  Top: FSM, step counter, optional stat counters.
// TESTING
//  1 Reset: n_rst=0 mid-STEP (o_iter=5) -> next sample IDLE, o_reg_step=0, o_start_ready=1, o_iter=0.
//  2 Nominal: start at T0, i_reg_lsb=3'b011 held ->
//    - o_reg_load at T1; 16 o_reg_step cycles with en=1, x2=1, neg=0.
//    - o_done_valid at T18.
//  3 Recode sweep: drive i_reg_lsb 000..111 during STEP -> en/neg/x2 exactly per table, one value per cycle.
//  4 Backpressure: i_done_ready=0 for 10 cycles ->
//    - o_done_valid held; a second i_start_valid is ignored (o_start_ready=0).
//    - Accepted only after the handshake.
//  5 Abort: i_abort at the STEP cycle with o_iter=7 -> IDLE next cycle, no o_done_valid, new start accepted.
//  6 BOOTH_STAT_EN: 3 completed multiplies with i_reg_lsb=3'b000 then one with 3'b001 ->
//    - o_op_count=4, o_nz_digits=16.
//    - An aborted operation does not increment o_op_count.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit recoder for the booth_seq_ctrl sequencer.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } booth_state_t;

    typedef struct packed {
        logic en;
        logic neg;
        logic x2;
    } booth_pp_t;

    // {P[1],P[0],P[-1]} -> digit in {-2,-1,0,+1,+2} as enable/negate/double
    function automatic booth_pp_t booth_recode(input logic [2:0] bits);
        booth_pp_t pp;
        pp = '0;
        case (bits)
            3'b001, 3'b010: begin pp.en = 1'b1; end
            3'b011:         begin pp.en = 1'b1; pp.x2 = 1'b1; end
            3'b100:         begin pp.en = 1'b1; pp.neg = 1'b1; pp.x2 = 1'b1; end
            3'b101, 3'b110: begin pp.en = 1'b1; pp.neg = 1'b1; end
            default:        pp = '0;
        endcase
        return pp;
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Partial-product select for the current Booth digit; forced to zero outside add-and-shift cycles.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0] reg_lsb,
    input  logic       step_active,
    output booth_pp_t  pp
);

    always_comb begin
        pp = '0;
        if (step_active) begin
            pp = booth_recode(reg_lsb);
        end
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for an iterative radix-4 Booth multiplier: load, ITERS add-and-shift steps, held done.
// Optional statistics counters are built when BOOTH_STAT_EN is defined.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH_REGISTER = 32,
    localparam int ITERS = WIDTH_REGISTER / 2,
    localparam int CW    = $clog2(ITERS + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_start_valid,
    output logic          o_start_ready,
    input  logic          i_abort,
    input  logic [2:0]    i_reg_lsb,
    output logic          o_reg_load,
    output logic          o_reg_step,
    output logic          o_pp_en,
    output logic          o_pp_neg,
    output logic          o_pp_x2,
    output logic [CW-1:0] o_iter,
    output logic          o_busy,
    output logic          o_done_valid,
`ifdef BOOTH_STAT_EN
    output logic [15:0]   o_op_count,
    output logic [15:0]   o_nz_digits,
`endif
    input  logic          i_done_ready
);

    booth_state_t  state_reg, state_next;
    logic [CW-1:0] iter_reg, iter_next;
    booth_pp_t     pp;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            iter_reg  <= iter_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        iter_next  = iter_reg;
        case (state_reg)
            IDLE: begin
                if (i_start_valid) state_next = LOAD;
            end
            LOAD: begin
                iter_next  = '0;
                state_next = STEP;
            end
            STEP: begin
                if (iter_reg < CW'(ITERS)) iter_next = iter_reg + CW'(1);
                if (iter_reg >= CW'(ITERS - 1)) state_next = DONE;
            end
            DONE: begin
                if (i_done_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort wins over a same-cycle done handshake: the result is dropped.
        if (i_abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            iter_next  = '0;
        end
    end

    assign o_start_ready = (state_reg == IDLE);
    assign o_reg_load    = (state_reg == LOAD);
    assign o_reg_step    = (state_reg == STEP);
    assign o_busy        = (state_reg == LOAD) || (state_reg == STEP);
    assign o_done_valid  = (state_reg == DONE);
    assign o_iter        = iter_reg;

    booth_recoder u_recoder (
        .reg_lsb     (i_reg_lsb),
        .step_active (o_reg_step),
        .pp          (pp)
    );

    assign o_pp_en  = pp.en;
    assign o_pp_neg = pp.neg;
    assign o_pp_x2  = pp.x2;

`ifdef BOOTH_STAT_EN
    logic [15:0] op_count_reg;
    logic [15:0] nz_digits_reg;
    logic        done_fire;

    assign done_fire = o_done_valid && i_done_ready && !i_abort;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op_count_reg  <= '0;
            nz_digits_reg <= '0;
        end else begin
            if (done_fire && (op_count_reg != 16'hFFFF)) op_count_reg <= op_count_reg + 16'd1;
            if (pp.en && (nz_digits_reg != 16'hFFFF)) nz_digits_reg <= nz_digits_reg + 16'd1;
        end
    end

    assign o_op_count  = op_count_reg;
    assign o_nz_digits = nz_digits_reg;
`endif

endmodule
